fusion_mac_unit: RTL and testbench

- Pipelined, parametrised bit-fusion multiply-accumulate engine.
- Each beat carries LANES 8-bit operand pairs. Each pair is decomposed into 2/4/8-bit elements, selected independently for a and b at run time, with per-operand signedness.
- All element products in a beat are reduced into one accumulator. The dot product is emitted on a valid/ready output when the last beat of a vector arrives.
- Sits between the operand buffers and the output/activation stage.

---
 rtl/fusion_mac_unit.sv | 192 +++++++++++++++++++
 tb/tb_fusion_mac_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fusion_mac_unit.sv
// Bit-fusion dot-product MAC: 2/4/8-bit elements per operand, per-operand signedness, LANES byte pairs per beat.
// Latency 3 edges from last-beat accept to out_valid; whole pipe stalls while out_valid && !out_ready.
// Optional FUSION_MAC_SAT_EN: saturating accumulator with sticky out_sat flag.
module fusion_mac_unit #(
    parameter int LANES = 4,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           cfga,
    input  logic [1:0]           cfgb,
    input  logic                 sa,
    input  logic                 sb,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [8*LANES-1:0]   a,
    input  logic [8*LANES-1:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_data,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_sat
);

    function automatic logic [2:0] f_num(input logic [1:0] cfg);
        case (cfg)
            2'b00:   return 3'd4;
            2'b01:   return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

    // Element k of a byte; the part-selects wrap k modulo the element count.
    function automatic logic signed [8:0] f_elem(input logic [7:0] w, input logic [1:0] cfg,
                                                 input logic sgn, input logic [1:0] k);
        logic [1:0] v2;
        logic [3:0] v4;
        v2 = w[{k, 1'b0} +: 2];
        v4 = w[{k[0], 2'b00} +: 4];
        case (cfg)
            2'b00:   return {{7{sgn & v2[1]}}, v2};
            2'b01:   return {{5{sgn & v4[3]}}, v4};
            default: return {sgn & w[7], w};
        endcase
    endfunction

    function automatic logic signed [ACC_W-1:0] f_lane(input logic [7:0] wa, input logic [7:0] wb,
                                                       input logic [1:0] ca, input logic [1:0] cb,
                                                       input logic xsa, input logic xsb);
        logic [2:0]              kn;
        logic signed [8:0]       ea;
        logic signed [8:0]       eb;
        logic signed [17:0]      prod;
        logic signed [ACC_W-1:0] s;
        kn = (f_num(ca) > f_num(cb)) ? f_num(ca) : f_num(cb);
        s  = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(kn)) begin
                ea   = f_elem(wa, ca, xsa, 2'(k));
                eb   = f_elem(wb, cb, xsb, 2'(k));
                prod = 18'(ea) * 18'(eb);
                s    = s + ACC_W'(prod);
            end
        end
        return s;
    endfunction

    logic                    w_en, w_in_rdy, w_accept, w_clip;
    logic [1:0]              w_cfga, w_cfgb;
    logic                    w_sa, w_sb;
    logic signed [ACC_W-1:0] w_sum, w_add;

    logic                    r_first;
    logic [1:0]              r_cfga, r_cfgb;
    logic                    r_sa, r_sb;
    logic                    r_e1_vld, r_e1_last, r_e1_sa, r_e1_sb;
    logic [1:0]              r_e1_cfga, r_e1_cfgb;
    logic [8*LANES-1:0]      r_e1_a, r_e1_b;
    logic                    r_e2_vld, r_e2_last;
    logic signed [ACC_W-1:0] r_e2_sum, r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_sat_acc;
    logic                    r_out_vld, r_out_sat;
    logic [ACC_W-1:0]        r_out_data;
    logic [CNT_W-1:0]        r_out_count;

    assign w_en     = !(r_out_vld && !out_ready);
    assign w_in_rdy = !rst && w_en;
    assign w_accept = in_valid && w_in_rdy;

    // The first beat of a vector uses live config; later beats use the copy latched with it.
    assign w_cfga = r_first ? cfga : r_cfga;
    assign w_cfgb = r_first ? cfgb : r_cfgb;
    assign w_sa   = r_first ? sa   : r_sa;
    assign w_sb   = r_first ? sb   : r_sb;

    always_comb begin
        w_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_sum = w_sum + f_lane(r_e1_a[8*l +: 8], r_e1_b[8*l +: 8],
                                   r_e1_cfga, r_e1_cfgb, r_e1_sa, r_e1_sb);
        end
    end

`ifdef FUSION_MAC_SAT_EN
    logic signed [ACC_W:0] w_add_full;
    assign w_add_full = {r_acc[ACC_W-1], r_acc} + {r_e2_sum[ACC_W-1], r_e2_sum};
    assign w_clip     = w_add_full[ACC_W] != w_add_full[ACC_W-1];
    assign w_add      = !w_clip ? w_add_full[ACC_W-1:0]
                      : (w_add_full[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}});
`else
    assign w_clip = 1'b0;
    assign w_add  = r_acc + r_e2_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_first     <= 1'b1;
            r_cfga      <= '0;
            r_cfgb      <= '0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_e1_vld    <= 1'b0;
            r_e1_last   <= 1'b0;
            r_e1_cfga   <= '0;
            r_e1_cfgb   <= '0;
            r_e1_sa     <= 1'b0;
            r_e1_sb     <= 1'b0;
            r_e1_a      <= '0;
            r_e1_b      <= '0;
            r_e2_vld    <= 1'b0;
            r_e2_last   <= 1'b0;
            r_e2_sum    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat_acc   <= 1'b0;
            r_out_vld   <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            if (r_out_vld && out_ready)
                r_out_vld <= 1'b0;
            if (w_en) begin
                r_e1_vld <= w_accept;
                if (w_accept) begin
                    r_e1_a    <= a;
                    r_e1_b    <= b;
                    r_e1_last <= in_last;
                    r_e1_cfga <= w_cfga;
                    r_e1_cfgb <= w_cfgb;
                    r_e1_sa   <= w_sa;
                    r_e1_sb   <= w_sb;
                    if (r_first) begin
                        r_cfga <= cfga;
                        r_cfgb <= cfgb;
                        r_sa   <= sa;
                        r_sb   <= sb;
                    end
                    r_first <= in_last;
                end
                r_e2_vld  <= r_e1_vld;
                r_e2_last <= r_e1_last;
                r_e2_sum  <= w_sum;
                if (r_e2_vld) begin
                    if (r_e2_last) begin
                        r_out_vld   <= 1'b1;
                        r_out_data  <= w_add;
                        r_out_count <= r_cnt + CNT_W'(1);
                        r_out_sat   <= r_sat_acc | w_clip;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_sat_acc   <= 1'b0;
                    end else begin
                        r_acc     <= w_add;
                        r_cnt     <= r_cnt + CNT_W'(1);
                        r_sat_acc <= r_sat_acc | w_clip;
                    end
                end
            end
        end
    end

    assign in_ready  = w_in_rdy;
    assign out_valid = r_out_vld;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_fusion_mac_unit.sv
// Bench for fusion_mac_unit: table of single-beat vectors plus hand sequences; scoreboard queue on the main instance.
module tb_fusion_mac_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: 4 lanes, 3-bit beat counter so wrap is reachable.
    logic        rst, sa, sb, in_valid, in_last, out_ready;
    logic [1:0]  cfga, cfgb;
    logic [31:0] a, b;
    logic        in_ready, out_valid, out_sat;
    logic [31:0] out_data;
    logic [2:0]  out_count;

    fusion_mac_unit #(.LANES(4), .ACC_W(32), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .cfga(cfga), .cfgb(cfgb), .sa(sa), .sb(sb),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_sat(out_sat)
    );

    // Narrow-accumulator instance for overflow behaviour.
    logic        s_sa, s_sb, s_in_valid, s_in_last, s_out_ready;
    logic [1:0]  s_cfga, s_cfgb;
    logic [7:0]  s_a, s_b;
    logic        s_in_ready, s_out_valid, s_out_sat;
    logic [17:0] s_out_data;
    logic [15:0] s_out_count;

    fusion_mac_unit #(.LANES(1), .ACC_W(18), .CNT_W(16)) dut_s (
        .clk(clk), .rst(rst), .cfga(s_cfga), .cfgb(s_cfgb), .sa(s_sa), .sb(s_sb),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_last(s_in_last), .a(s_a), .b(s_b),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_count(s_out_count), .out_sat(s_out_sat)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        longint d;
        longint c;
        longint s;
    } exp_t;
    exp_t sb_q[$];

    task automatic push(input longint d, input longint c, input longint s);
        exp_t e;
        e.d = d; e.c = c; e.s = s;
        sb_q.push_back(e);
    endtask

    // Samples 1 time unit before each rising edge, i.e. the values the handshake sees.
    always begin
        exp_t e;
        @(negedge clk);
        #4;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got data %0d, expected no result", $signed(out_data));
            end else begin
                e = sb_q.pop_front();
                chk("res_data", longint'($signed(out_data)), e.d);
                chk("res_count", longint'(out_count), e.c);
                chk("res_sat", longint'(out_sat), e.s);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the beat is taken.
    task automatic send(input logic [1:0] ca, input logic [1:0] cb, input logic xsa, input logic xsb,
                        input logic [31:0] xa, input logic [31:0] xb, input logic last);
        int n;
        cfga = ca; cfgb = cb; sa = xsa; sb = xsb; a = xa; b = xb;
        in_last = last; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready 0, expected 1 within 100 cycles");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb_q.size(), 0);
    endtask

    typedef struct {
        logic [1:0]  ca, cb;
        logic        xsa, xsb;
        logic [31:0] xa, xb;
        longint      exp;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int n, t0;
        longint sat_exp_d, sat_exp_s;

        tbl[0] = '{2'b10, 2'b10, 1'b0, 1'b0, 32'h04030201, 32'h01010101, 10};
        tbl[1] = '{2'b10, 2'b10, 1'b1, 1'b1, 32'h00000080, 32'h0000007F, -16256};
        tbl[2] = '{2'b01, 2'b01, 1'b1, 1'b1, 32'h0000007F, 32'h00000023, 11};
        tbl[3] = '{2'b00, 2'b10, 1'b0, 1'b0, 32'h000000E4, 32'h00000002, 12};
        tbl[4] = '{2'b00, 2'b00, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 16};
        tbl[5] = '{2'b10, 2'b01, 1'b1, 1'b0, 32'h000000FE, 32'h000000F3, -36};
        tbl[6] = '{2'b10, 2'b00, 1'b0, 1'b1, 32'h00000010, 32'h0000001B, -32};
        tbl[7] = '{2'b11, 2'b11, 1'b0, 1'b0, 32'h00000003, 32'h00000005, 15};
        tbl[8] = '{2'b01, 2'b00, 1'b0, 1'b0, 32'h00000021, 32'h000000E4, 10};
        tbl[9] = '{2'b10, 2'b10, 1'b1, 1'b1, 32'h80808080, 32'h80808080, 65536};

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        cfga = 2'b10; cfgb = 2'b10; sa = 1'b0; sb = 1'b0; a = '0; b = '0;
        s_in_valid = 1'b0; s_in_last = 1'b0; s_out_ready = 1'b1;
        s_cfga = 2'b10; s_cfgb = 2'b10; s_sa = 1'b1; s_sb = 1'b1; s_a = '0; s_b = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_sat", out_sat, 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_in_ready", in_ready, 1);
        @(negedge clk);

        // Single-beat latency: accepted at edge 1, out_valid visible after edge 3.
        push(65025, 1, 0);
        send(2'b10, 2'b10, 1'b0, 1'b0, 32'hFF, 32'hFF, 1'b1);
        chk("lat_edge1", out_valid, 0);
        @(negedge clk);
        chk("lat_edge2", out_valid, 0);
        @(negedge clk);
        chk("lat_edge3", out_valid, 1);
        drain();

        // Back-to-back single-beat vectors: one beat per cycle.
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            push(tbl[i].exp, 1, 0);
            send(tbl[i].ca, tbl[i].cb, tbl[i].xsa, tbl[i].xsb, tbl[i].xa, tbl[i].xb, 1'b1);
        end
        chk("throughput_cycles", cyc - t0, 10);
        drain();

        // 9-beat vector: config changes after the first beat are ignored; count wraps mod 8.
        push(45, 1, 0);
        send(2'b10, 2'b10, 1'b0, 1'b0, 32'h05, 32'h01, 1'b0);
        for (int i = 1; i < 9; i++)
            send(2'b00, 2'b01, 1'b1, 1'b1, 32'h05, 32'h01, i == 8);
        push(12, 1, 0);
        send(2'b00, 2'b10, 1'b0, 1'b0, 32'hE4, 32'h02, 1'b1);
        drain();

        // Output backpressure: result held, input blocked, nothing lost on release.
        out_ready = 1'b0;
        push(1024, 4, 0);
        for (int i = 0; i < 4; i++)
            send(2'b10, 2'b10, 1'b0, 1'b0, 32'h10, 32'h10, i == 3);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_out_valid", out_valid, 1);
        cfga = 2'b10; cfgb = 2'b10; sa = 1'b0; sb = 1'b0; a = 32'h2; b = 32'h7;
        in_last = 1'b1; in_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_hold_valid", out_valid, 1);
            chk("stall_hold_data", out_data, 1024);
            chk("stall_hold_count", out_count, 4);
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1);
        push(14, 1, 0);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        drain();

        // Reset in the middle of a vector discards the partial sum.
        send(2'b10, 2'b10, 1'b0, 1'b0, 32'h09, 32'h09, 1'b0);
        send(2'b10, 2'b10, 1'b0, 1'b0, 32'h09, 32'h09, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        push(15, 1, 0);
        send(2'b10, 2'b10, 1'b0, 1'b0, 32'h03, 32'h05, 1'b1);
        drain();
        repeat (5) @(negedge clk);

        // 9 x 16129 = 145161 exceeds the 18-bit signed range.
`ifdef FUSION_MAC_SAT_EN
        sat_exp_d = 131071;
        sat_exp_s = 1;
`else
        sat_exp_d = -116983;
        sat_exp_s = 0;
`endif
        for (int i = 0; i < 9; i++) begin
            s_a = 8'h7F; s_b = 8'h7F; s_in_last = (i == 8); s_in_valid = 1'b1;
            @(negedge clk);
        end
        s_in_valid = 1'b0; s_in_last = 1'b0;
        n = 0;
        while (!s_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ovf_valid", s_out_valid, 1);
        chk("ovf_data", longint'($signed(s_out_data)), sat_exp_d);
        chk("ovf_sat", s_out_sat, sat_exp_s);
        chk("ovf_count", s_out_count, 9);
        s_a = 8'h01; s_b = 8'h01; s_in_last = 1'b1; s_in_valid = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0; s_in_last = 1'b0;
        n = 0;
        while (!s_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("next_valid", s_out_valid, 1);
        chk("next_data", longint'($signed(s_out_data)), 1);
        chk("next_sat_clear", s_out_sat, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
